mux_rr_n: RTL and testbench

//  Parametrised N-channel, W-bit registered multiplexer; successor to the fixed 4:1 x 4-bit mux.

---
 rtl/mux_rr_n.sv | 115 +++++++++++
 tb/tb_mux_rr_n.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mux_rr_n.sv
// mux_rr_n: N-channel, W-bit registered multiplexer with per-channel
// valid/ready handshakes, a single output register with backpressure, and
// two select modes: manual (external select) or round-robin over valid channels.
module mux_rr_n #(
  parameter int N = 4,
  parameter int W = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  input  logic              mode,
  input  logic [SELW-1:0]   sel_man,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  output logic [SELW-1:0]   out_ch
);

  logic [W-1:0]    outData_q, outData_d;
  logic            outValid_q, outValid_d;
  logic [SELW-1:0] outCh_q, outCh_d;
  logic [SELW-1:0] ptr_q, ptr_d;

  logic [SELW-1:0] gnt;
  logic            hit;
  logic            load;
  logic            found;
  logic [SELW:0]   idx;
  logic [W-1:0]    selData;
  logic [N-1:0]    readyVec;

  // Output register may take a new word when empty or being drained; nothing is consumed while in reset.
  assign load = rst_n & (~outValid_q | out_ready);

  // Grant selection: manual select, or first valid channel scanning upward from the round-robin pointer with wrap at N-1.
  always_comb begin
    gnt   = '0;
    hit   = 1'b0;
    found = 1'b0;
    idx   = '0;
    if (!mode) begin
      gnt = sel_man;
      if ({1'b0, sel_man} < (SELW+1)'(N)) begin
        hit = in_valid[sel_man];
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        idx = {1'b0, ptr_q} + (SELW+1)'(i);
        if (idx >= (SELW+1)'(N)) begin
          idx = idx - (SELW+1)'(N);
        end
        if (!found && in_valid[idx[SELW-1:0]]) begin
          found = 1'b1;
          gnt   = idx[SELW-1:0];
        end
      end
      hit = found;
    end
  end

  // Pick the granted channel's data word and build the one-hot ready vector.
  always_comb begin
    selData  = '0;
    readyVec = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt == SELW'(k)) begin
        selData     = in_data[k*W +: W];
        readyVec[k] = load & hit;
      end
    end
  end

  assign in_ready = readyVec;

  // Next-state for the output register and round-robin pointer; everything holds unless a load happens.
  always_comb begin
    outData_d  = outData_q;
    outValid_d = outValid_q;
    outCh_d    = outCh_q;
    ptr_d      = ptr_q;
    if (load) begin
      outValid_d = hit;
      if (hit) begin
        outData_d = selData;
        outCh_d   = gnt;
        if (mode) begin
          ptr_d = (gnt == SELW'(N-1)) ? '0 : gnt + 1'b1;
        end
      end
    end
  end

  // State registers; reset clears the output immediately and discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outData_q  <= '0;
      outValid_q <= 1'b0;
      outCh_q    <= '0;
      ptr_q      <= '0;
    end else begin
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
      outCh_q    <= outCh_d;
      ptr_q      <= ptr_d;
    end
  end

  assign out_data  = outData_q;
  assign out_valid = outValid_q;
  assign out_ch    = outCh_q;

endmodule

// File: tb/tb_mux_rr_n.sv
// Testbench for mux_rr_n (N=4, W=4): table of directed vectors plus
// hand-written reset sequences.
module tb_mux_rr_n;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel_man;
  logic        out_ready;
  logic [3:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_ch;

  int checkCount;
  int passCount;

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic [15:0] data;
    logic        outReady;
    logic [3:0]  expReady;
    logic        expValid;
    logic [3:0]  expData;
    logic [1:0]  expCh;
  } vec_t;

  vec_t vecs[$];

  mux_rr_n #(.N(4), .W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel_man   (sel_man),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ch    (out_ch)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic addVec(input logic m, input logic [1:0] s, input logic [3:0] v,
                        input logic [15:0] d, input logic r, input logic [3:0] er,
                        input logic ev, input logic [3:0] ed, input logic [1:0] ec);
    vec_t t;
    t.mode = m; t.sel = s; t.valid = v; t.data = d; t.outReady = r;
    t.expReady = er; t.expValid = ev; t.expData = ed; t.expCh = ec;
    vecs.push_back(t);
  endtask

  task automatic applyStimulus(input logic m, input logic [1:0] s, input logic [3:0] v,
                               input logic [15:0] d, input logic r);
    mode      = m;
    sel_man   = s;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkOut(input string tag, input logic ev, input logic [3:0] ed, input logic [1:0] ec);
    checkOutput({tag, " out_valid"}, 16'(out_valid), 16'(ev));
    checkOutput({tag, " out_data"},  16'(out_data),  16'(ed));
    checkOutput({tag, " out_ch"},    16'(out_ch),    16'(ec));
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 2'd0, 4'h0, 16'h0, 1'b0);

    // Reset with random inputs: everything stays cleared, nothing ready.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      applyStimulus(1'($urandom), 2'($urandom), 4'($urandom), 16'($urandom), 1'($urandom));
      #1;
      checkOutput($sformatf("reset%0d in_ready", c), 16'(in_ready), 16'h0);
      checkOut($sformatf("reset%0d", c), 1'b0, 4'h0, 2'd0);
    end

    // Manual sweep over A,B,C,D.
    addVec(0, 0, 4'b1111, 16'hDCBA, 1, 4'b0001, 1, 4'hA, 0);
    addVec(0, 1, 4'b1111, 16'hDCBA, 1, 4'b0010, 1, 4'hB, 1);
    addVec(0, 2, 4'b1111, 16'hDCBA, 1, 4'b0100, 1, 4'hC, 2);
    addVec(0, 3, 4'b1111, 16'hDCBA, 1, 4'b1000, 1, 4'hD, 3);
    // Round-robin, all valid for 8 cycles.
    for (int j = 0; j < 8; j++) begin
      addVec(1, 0, 4'b1111, 16'hDCBA, 1, 4'(1 << (j % 4)), 1, 4'(4'hA + (j % 4)), 2'(j % 4));
    end
    // Round-robin with only channels 1 and 3 valid.
    addVec(1, 0, 4'b1010, 16'hDCBA, 1, 4'b0010, 1, 4'hB, 1);
    addVec(1, 0, 4'b1010, 16'hDCBA, 1, 4'b1000, 1, 4'hD, 3);
    addVec(1, 0, 4'b1010, 16'hDCBA, 1, 4'b0010, 1, 4'hB, 1);
    addVec(1, 0, 4'b1010, 16'hDCBA, 1, 4'b1000, 1, 4'hD, 3);
    // Pointer to 2, then an empty cycle leaves it there.
    addVec(1, 0, 4'b0010, 16'hDCBA, 1, 4'b0010, 1, 4'hB, 1);
    addVec(1, 0, 4'b0000, 16'hDCBA, 1, 4'b0000, 0, 4'hB, 1);
    addVec(1, 0, 4'b1111, 16'hDCBA, 1, 4'b0100, 1, 4'hC, 2);
    // Manual select on an invalid channel, then a manual hit; pointer (3) survives.
    addVec(0, 1, 4'b1101, 16'hDCBA, 1, 4'b0000, 0, 4'hC, 2);
    addVec(0, 0, 4'b1111, 16'hDCBA, 1, 4'b0001, 1, 4'hA, 0);
    addVec(1, 0, 4'b1111, 16'hDCBA, 1, 4'b1000, 1, 4'hD, 3);
    // Backpressure: load 5, hold for 3 cycles while inputs change, then drain.
    addVec(0, 0, 4'b0001, 16'hDCB5, 1, 4'b0001, 1, 4'h5, 0);
    addVec(0, 2, 4'b1111, 16'h1234, 0, 4'b0000, 1, 4'h5, 0);
    addVec(1, 3, 4'b1111, 16'h4321, 0, 4'b0000, 1, 4'h5, 0);
    addVec(0, 1, 4'b0110, 16'hFEDC, 0, 4'b0000, 1, 4'h5, 0);
    addVec(0, 2, 4'b1111, 16'h9876, 1, 4'b0100, 1, 4'h8, 2);
    addVec(1, 0, 4'b0000, 16'h9876, 1, 4'b0000, 0, 4'h8, 2);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].mode, vecs[i].sel, vecs[i].valid, vecs[i].data, vecs[i].outReady);
      #1;
      checkOutput($sformatf("vec%0d in_ready", i), 16'(in_ready), 16'(vecs[i].expReady));
      @(posedge clk);
      #1;
      checkOut($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expData, vecs[i].expCh);
    end

    // Async reset mid-stream: advance the pointer, then drop reset between edges.
    applyStimulus(1, 0, 4'b1111, 16'hDCBA, 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    checkOut("prereset", 1'b1, 4'hB, 2'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOut("midreset", 1'b0, 4'h0, 2'd0);
    checkOutput("midreset in_ready", 16'(in_ready), 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("postreset in_ready", 16'(in_ready), 16'b0001);
    @(posedge clk);
    #1;
    checkOut("postreset", 1'b1, 4'hA, 2'd0);
    @(posedge clk);
    #1;
    checkOut("postreset2", 1'b1, 4'hB, 2'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
